// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: datapath widths and load-type encodings.
package cpu_defs_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  // Load-type encodings carried on ld_op; anything else behaves as LD_W.
  localparam logic [2:0] LD_W  = 3'd0;
  localparam logic [2:0] LD_B  = 3'd1;
  localparam logic [2:0] LD_BU = 3'd2;
  localparam logic [2:0] LD_H  = 3'd3;
  localparam logic [2:0] LD_HU = 3'd4;

endpackage

// File: rtl/ld_extend.sv
// Load data extraction: selects byte/halfword by address offset and extends it.
module ld_extend
  import cpu_defs_pkg::*;
(
  input  logic [2:0]      ld_op,
  input  logic [1:0]      off,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] ext
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane selection; halfword offset uses only off[1] since alignment is guaranteed.
  always_comb begin
    byte_s = rdata[{off, 3'b000} +: 8];
    half_s = rdata[{off[1], 4'b0000} +: 16];
  end

  // Extension by load type; reserved encodings fall back to a full word.
  always_comb begin
    ext = rdata;
    case (ld_op)
      LD_W:    ext = rdata;
      LD_B:    ext = {{24{byte_s[7]}}, byte_s};
      LD_BU:   ext = {24'h00_0000, byte_s};
      LD_H:    ext = {{16{half_s[15]}}, half_s};
      LD_HU:   ext = {16'h0000, half_s};
      default: ext = rdata;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: one-entry pipeline register feeding the register file,
// decode bypass, trace port and retired-instruction counter.
module wb_stage
  import cpu_defs_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ms_to_ws_valid,
  output logic              ws_allowin,
  input  logic [XLEN-1:0]   ms_pc,
  input  logic              ms_gr_we,
  input  logic [REG_AW-1:0] ms_dest,
  input  logic [XLEN-1:0]   ms_result,
  input  logic              ms_res_from_mem,
  input  logic [2:0]        ms_ld_op,
  input  logic [XLEN-1:0]   ms_rdata,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [XLEN-1:0]   rf_wdata,
  output logic              ws_fwd_valid,
  output logic [REG_AW-1:0] ws_fwd_dest,
  output logic [XLEN-1:0]   ws_fwd_data,
  output logic [31:0]       debug_wb_pc,
  output logic [3:0]        debug_wb_rf_we,
  output logic [REG_AW-1:0] debug_wb_rf_wnum,
  output logic [XLEN-1:0]   debug_wb_rf_wdata,
  output logic [63:0]       instret
);

  // Held instruction state.
  logic              ws_valid_q,     ws_valid_d;
  logic [XLEN-1:0]   pc_q,           pc_d;
  logic              gr_we_q,        gr_we_d;
  logic [REG_AW-1:0] dest_q,         dest_d;
  logic [XLEN-1:0]   result_q,       result_d;
  logic              res_from_mem_q, res_from_mem_d;
  logic [2:0]        ld_op_q,        ld_op_d;
  logic [XLEN-1:0]   rdata_q,        rdata_d;
  logic [63:0]       instret_q,      instret_d;

  logic              ws_ready_go_s;
  logic              accept_s;
  logic [XLEN-1:0]   ld_ext_s;
  logic [XLEN-1:0]   final_result_s;
  logic              rf_we_s;

  // WB never stalls today; a future stall source only needs to drive this.
  assign ws_ready_go_s = 1'b1;
  assign ws_allowin    = !ws_valid_q || ws_ready_go_s;
  assign accept_s      = ms_to_ws_valid && ws_allowin;

  // Next-state: latch on accept, drain to empty when nothing is presented.
  always_comb begin
    ws_valid_d     = ws_valid_q;
    pc_d           = pc_q;
    gr_we_d        = gr_we_q;
    dest_d         = dest_q;
    result_d       = result_q;
    res_from_mem_d = res_from_mem_q;
    ld_op_d        = ld_op_q;
    rdata_d        = rdata_q;
    if (accept_s) begin
      ws_valid_d     = 1'b1;
      pc_d           = ms_pc;
      gr_we_d        = ms_gr_we;
      dest_d         = ms_dest;
      result_d       = ms_result;
      res_from_mem_d = ms_res_from_mem;
      ld_op_d        = ms_ld_op;
      rdata_d        = ms_rdata;
    end else if (ws_allowin) begin
      ws_valid_d = 1'b0;
    end else begin
      ws_valid_d = ws_valid_q;
    end
  end

  // Retired-instruction counter: counts every cycle an instruction is held.
  always_comb begin
    if (ws_valid_q) begin
      instret_d = instret_q + 64'd1;
    end else begin
      instret_d = instret_q;
    end
  end

  // Pipeline register with synchronous reset taking priority over accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      ws_valid_q     <= 1'b0;
      pc_q           <= RESET_PC;
      gr_we_q        <= 1'b0;
      dest_q         <= {REG_AW{1'b0}};
      result_q       <= {XLEN{1'b0}};
      res_from_mem_q <= 1'b0;
      ld_op_q        <= 3'd0;
      rdata_q        <= {XLEN{1'b0}};
      instret_q      <= 64'd0;
    end else begin
      ws_valid_q     <= ws_valid_d;
      pc_q           <= pc_d;
      gr_we_q        <= gr_we_d;
      dest_q         <= dest_d;
      result_q       <= result_d;
      res_from_mem_q <= res_from_mem_d;
      ld_op_q        <= ld_op_d;
      rdata_q        <= rdata_d;
      instret_q      <= instret_d;
    end
  end

  ld_extend u_ld_extend (
    .ld_op (ld_op_q),
    .off   (result_q[1:0]),
    .rdata (rdata_q),
    .ext   (ld_ext_s)
  );

  // Result selection and all outward views, driven from WB registers only.
  always_comb begin
    if (res_from_mem_q) begin
      final_result_s = ld_ext_s;
    end else begin
      final_result_s = result_q;
    end
    rf_we_s = ws_valid_q && gr_we_q;
  end

  assign rf_we             = rf_we_s;
  assign rf_waddr          = dest_q;
  assign rf_wdata          = final_result_s;
  // x0 writes reach the register file but are never worth bypassing.
  assign ws_fwd_valid      = rf_we_s && (dest_q != {REG_AW{1'b0}});
  assign ws_fwd_dest       = dest_q;
  assign ws_fwd_data       = final_result_s;
  assign debug_wb_pc       = ws_valid_q ? pc_q : RESET_PC;
  assign debug_wb_rf_we    = {4{rf_we_s}};
  assign debug_wb_rf_wnum  = dest_q;
  assign debug_wb_rf_wdata = final_result_s;
  assign instret           = instret_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed, table-driven bench for wb_stage.
module tb_wb_stage;

  localparam logic [31:0] RST_PC = 32'hBFC0_0000;

  logic        clk;
  logic        reset;
  logic        ms_to_ws_valid;
  logic        ws_allowin;
  logic [31:0] ms_pc;
  logic        ms_gr_we;
  logic [4:0]  ms_dest;
  logic [31:0] ms_result;
  logic        ms_res_from_mem;
  logic [2:0]  ms_ld_op;
  logic [31:0] ms_rdata;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        ws_fwd_valid;
  logic [4:0]  ws_fwd_dest;
  logic [31:0] ws_fwd_data;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_we;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;
  logic [63:0] instret;

  int total_cnt = 0;
  int pass_cnt  = 0;

  wb_stage #(.RESET_PC(RST_PC)) dut (
    .clk               (clk),
    .reset             (reset),
    .ms_to_ws_valid    (ms_to_ws_valid),
    .ws_allowin        (ws_allowin),
    .ms_pc             (ms_pc),
    .ms_gr_we          (ms_gr_we),
    .ms_dest           (ms_dest),
    .ms_result         (ms_result),
    .ms_res_from_mem   (ms_res_from_mem),
    .ms_ld_op          (ms_ld_op),
    .ms_rdata          (ms_rdata),
    .rf_we             (rf_we),
    .rf_waddr          (rf_waddr),
    .rf_wdata          (rf_wdata),
    .ws_fwd_valid      (ws_fwd_valid),
    .ws_fwd_dest       (ws_fwd_dest),
    .ws_fwd_data       (ws_fwd_data),
    .debug_wb_pc       (debug_wb_pc),
    .debug_wb_rf_we    (debug_wb_rf_we),
    .debug_wb_rf_wnum  (debug_wb_rf_wnum),
    .debug_wb_rf_wdata (debug_wb_rf_wdata),
    .instret           (instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference register file, x0 hardwired to zero.
  logic [31:0] ref_rf [32];
  always @(posedge clk) begin
    if (rf_we && rf_waddr != 5'd0) ref_rf[rf_waddr] <= rf_wdata;
  end

  typedef struct {
    logic [31:0] pc;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] result;
    logic        mem;
    logic [2:0]  op;
    logic [31:0] rdata;
    logic [31:0] exp_wdata;
    logic        exp_we;
    logic        exp_fwd;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic v, input vec_t t);
    ms_to_ws_valid  = v;
    ms_pc           = t.pc;
    ms_gr_we        = t.gr_we;
    ms_dest         = t.dest;
    ms_result       = t.result;
    ms_res_from_mem = t.mem;
    ms_ld_op        = t.op;
    ms_rdata        = t.rdata;
  endtask

  task automatic present_alu(input logic v, input logic [31:0] pc, input logic [4:0] d, input logic [31:0] r);
    vec_t t;
    t = '{pc, 1'b1, d, r, 1'b0, 3'd0, 32'h0, r, 1'b1, 1'b1};
    present(v, t);
  endtask

  initial begin
    for (int k = 0; k < 32; k++) ref_rf[k] = 32'h0;

    //          pc            we    dest   result        mem   op    rdata         exp_wdata     we    fwd
    vecs[0]  = '{32'h1C000000, 1'b1, 5'd5, 32'h12345678, 1'b0, 3'd0, 32'h00000000, 32'h12345678, 1'b1, 1'b1};
    vecs[1]  = '{32'h1C000004, 1'b1, 5'd6, 32'h1C001001, 1'b1, 3'd1, 32'h80FF7F01, 32'h0000007F, 1'b1, 1'b1};
    vecs[2]  = '{32'h1C000008, 1'b1, 5'd6, 32'h1C001002, 1'b1, 3'd1, 32'h80FF7F01, 32'hFFFFFFFF, 1'b1, 1'b1};
    vecs[3]  = '{32'h1C00000C, 1'b1, 5'd8, 32'h1C001003, 1'b1, 3'd2, 32'h80FF7F01, 32'h00000080, 1'b1, 1'b1};
    vecs[4]  = '{32'h1C000010, 1'b1, 5'd9, 32'h1C001002, 1'b1, 3'd3, 32'h80FF7F01, 32'hFFFF80FF, 1'b1, 1'b1};
    vecs[5]  = '{32'h1C000014, 1'b1, 5'd10, 32'h1C001000, 1'b1, 3'd4, 32'h80FF7F01, 32'h00007F01, 1'b1, 1'b1};
    vecs[6]  = '{32'h1C000018, 1'b1, 5'd11, 32'h1C001000, 1'b1, 3'd0, 32'h80FF7F01, 32'h80FF7F01, 1'b1, 1'b1};
    vecs[7]  = '{32'h1C00001C, 1'b1, 5'd0, 32'hDEADBEEF, 1'b0, 3'd0, 32'h00000000, 32'hDEADBEEF, 1'b1, 1'b0};
    vecs[8]  = '{32'h1C000020, 1'b1, 5'd7, 32'h0BADF00D, 1'b0, 3'd0, 32'h00000000, 32'h0BADF00D, 1'b1, 1'b1};
    vecs[9]  = '{32'h1C000024, 1'b0, 5'd12, 32'h55AA55AA, 1'b0, 3'd0, 32'h00000000, 32'h55AA55AA, 1'b0, 1'b0};
    vecs[10] = '{32'h1C000028, 1'b1, 5'd13, 32'h1C001001, 1'b1, 3'd5, 32'h80FF7F01, 32'h80FF7F01, 1'b1, 1'b1};

    // Reset state.
    reset = 1'b1;
    present_alu(1'b0, 32'h0, 5'd0, 32'h0);
    step();
    step();
    reset = 1'b0;
    chk("rst_rf_we", {63'd0, rf_we}, 64'd0);
    chk("rst_fwd_valid", {63'd0, ws_fwd_valid}, 64'd0);
    chk("rst_dbg_we", {60'd0, debug_wb_rf_we}, 64'd0);
    chk("rst_allowin", {63'd0, ws_allowin}, 64'd1);
    chk("rst_instret", instret, 64'd0);
    chk("rst_dbg_pc", {32'd0, debug_wb_pc}, {32'd0, RST_PC});
    chk("rst_waddr", {59'd0, rf_waddr}, 64'd0);
    chk("rst_wdata", {32'd0, rf_wdata}, 64'd0);

    // Table: back-to-back accepts, each visible the cycle after its edge.
    for (int i = 0; i < 11; i++) begin
      present(1'b1, vecs[i]);
      step();
      chk($sformatf("v%0d_rf_we", i), {63'd0, rf_we}, {63'd0, vecs[i].exp_we});
      chk($sformatf("v%0d_waddr", i), {59'd0, rf_waddr}, {59'd0, vecs[i].dest});
      chk($sformatf("v%0d_wdata", i), {32'd0, rf_wdata}, {32'd0, vecs[i].exp_wdata});
      chk($sformatf("v%0d_fwd_valid", i), {63'd0, ws_fwd_valid}, {63'd0, vecs[i].exp_fwd});
      chk($sformatf("v%0d_fwd_dest", i), {59'd0, ws_fwd_dest}, {59'd0, vecs[i].dest});
      chk($sformatf("v%0d_fwd_data", i), {32'd0, ws_fwd_data}, {32'd0, vecs[i].exp_wdata});
      chk($sformatf("v%0d_dbg_pc", i), {32'd0, debug_wb_pc}, {32'd0, vecs[i].pc});
      chk($sformatf("v%0d_dbg_we", i), {60'd0, debug_wb_rf_we}, {60'd0, {4{vecs[i].exp_we}}});
      chk($sformatf("v%0d_dbg_wnum", i), {59'd0, debug_wb_rf_wnum}, {59'd0, vecs[i].dest});
      chk($sformatf("v%0d_dbg_wdata", i), {32'd0, debug_wb_rf_wdata}, {32'd0, vecs[i].exp_wdata});
      chk($sformatf("v%0d_allowin", i), {63'd0, ws_allowin}, 64'd1);
      if (i == 1) chk("x5_after_commit", {32'd0, ref_rf[5]}, 64'h12345678);
    end

    // Bubble and throughput from a clean reset: valid 1,1,0,1 then idle.
    reset = 1'b1;
    present_alu(1'b0, 32'h0, 5'd0, 32'h0);
    step();
    reset = 1'b0;
    begin
      logic [3:0]  vpat;
      logic [4:0]  we_exp;
      logic [63:0] ir_exp [5];
      vpat   = 4'b1011;   // bit i = valid in cycle i: 1,1,0,1
      we_exp = 5'b01011;  // bit i = rf_we after edge i: 1,1,0,1,0
      ir_exp = '{64'd0, 64'd1, 64'd2, 64'd2, 64'd3};
      for (int c = 0; c < 5; c++) begin
        if (c < 4) present_alu(vpat[c], 32'h1C000100 + 32'(c * 4), 5'd3, 32'h100 + 32'(c));
        else       present_alu(1'b0, 32'h0, 5'd3, 32'h0);
        step();
        chk($sformatf("bub%0d_rf_we", c), {63'd0, rf_we}, {63'd0, we_exp[c]});
        chk($sformatf("bub%0d_instret", c), instret, ir_exp[c]);
        if (we_exp[c])
          chk($sformatf("bub%0d_dbg_pc", c), {32'd0, debug_wb_pc}, {32'd0, 32'h1C000100 + 32'(c * 4)});
        else
          chk($sformatf("bub%0d_dbg_pc", c), {32'd0, debug_wb_pc}, {32'd0, RST_PC});
      end
    end

    // Reset mid-stream: the instruction presented with reset is dropped.
    present_alu(1'b1, 32'h1C000200, 5'd4, 32'hAAAA0001);
    step();
    present_alu(1'b1, 32'h1C000204, 5'd4, 32'hAAAA0002);
    step();
    chk("mid_pre_instret", instret, 64'd4);
    reset = 1'b1;
    present_alu(1'b1, 32'h1C000208, 5'd9, 32'hCAFE0009);
    step();
    chk("mid_rf_we", {63'd0, rf_we}, 64'd0);
    chk("mid_instret", instret, 64'd0);
    chk("mid_dbg_we", {60'd0, debug_wb_rf_we}, 64'd0);
    chk("mid_dbg_pc", {32'd0, debug_wb_pc}, {32'd0, RST_PC});
    chk("mid_dbg_wnum", {59'd0, debug_wb_rf_wnum}, 64'd0);
    reset = 1'b0;
    present_alu(1'b0, 32'h0, 5'd0, 32'h0);
    step();
    chk("mid_after_rf_we", {63'd0, rf_we}, 64'd0);
    chk("mid_after_instret", instret, 64'd0);
    chk("mid_after_dbg_pc", {32'd0, debug_wb_pc}, {32'd0, RST_PC});

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
